axi_mem_responder: RTL and testbench
====================================

// Module: axi_mem_responder
// PURPOSE
//  AXI4 responder (slave end) on Ariane req_t/resp_t structs, bridging to a single-port SRAM with 1-cycle read latency.
//  Consumes a req_t from an AXI_BUS.Slave-to-struct adapter or from a crossbar master port; returns resp_t.
//  Serves one transaction at a time (no write/read overlap) and fully handles FIXED/INCR bursts.
// PARAMETERS
//  AxiAddrWidth  64                   AXI address width
//  AxiDataWidth  64                   AXI data width = SRAM word width
//  AxiIdWidth    4                    AXI ID width; echoed on B/R
//  MemAddrWidth  16                   SRAM word-address width (depth 2**MemAddrWidth)
//  req_t         ariane_axi::req_t    AXI request struct type
//  resp_t        ariane_axi::resp_t   AXI response struct type
// PORTS
//  clk_i        in   1               clock
//  rst_ni       in   1               synchronous active-low reset
//  axi_req_i    in   req_t           AW/W/AR channels + b_ready/r_ready
//  axi_resp_o   out  resp_t          ready signals, B and R channels
//  mem_req_o    out  1               SRAM access strobe
//  mem_we_o     out  1               1 = write, 0 = read
//  mem_addr_o   out  MemAddrWidth    SRAM word address
//  mem_wdata_o  out  AxiDataWidth    write data
//  mem_be_o     out  AxiDataWidth/8  byte enables (= w.strb)
//  mem_rdata_i  in   AxiDataWidth    read data, valid cycle after read strobe
// BEHAVIOUR
//  Interface: one clock clk_i; reset rst_ni synchronous, active-low. Reset (also mid-burst): FSM->IDLE, all readys/valids/mem_req_o/mem_we_o=0,
//   regs cleared; in-flight transaction dropped, no B/R issued.
//  FSM: IDLE, WRITE, WRITE_RESP, READ_REQ, READ_DATA.
//  IDLE: aw_ready=ar_ready=1 only if exactly one of aw_valid/ar_valid is high, else per arbitration; capture id/addr/len/size/burst.
//   Both valid same cycle: round-robin via 1-bit last_grant (reset = read, so first conflict grants write); only the winner's ready is high.
//   AW accepted -> WRITE; AR accepted -> READ_REQ.
//  WRITE: w_ready=1; each w handshake same cycle drives mem_req_o=1, mem_we_o=1, mem_wdata_o=w.data, mem_be_o=w.strb, then advances address.
//   w.last or beat count == len -> WRITE_RESP (beat count governs; w.last mismatch ignored).
//  WRITE_RESP: b_valid=1, b.id=captured id, b.resp=OKAY; held stable until b_ready; then IDLE.
//  READ_REQ: mem_req_o=1, mem_we_o=0 at current address for one cycle -> READ_DATA.
//  READ_DATA: r.data registered from mem_rdata_i on entry; r_valid=1; r.id/r.resp stable; r.last=1 on beat len.
//   On r_ready: last beat -> IDLE; else advance address -> READ_REQ. Max throughput 1 beat / 2 cycles.
//  Address: word addr = addr[MemAddrWidth+log2(AxiDataWidth/8)-1 : log2(AxiDataWidth/8)]; upper bits dropped (aliasing).
//   INCR: addr += 1<<size, AxiAddrWidth-bit, wraps at 2**AxiAddrWidth. FIXED: unchanged. WRAP: treated as INCR. Beats = len+1 (1..256).
//  Narrow: strobes passed verbatim; read returns full word.
//  aw.atop ignored; upstream atomics filter required. All handshakes obey AXI valid/ready: outputs never drop valid before ready.
// CONFIGURATION
//  AXI_MEM_RANGE_CHECK_EN defined: beat whose addr >= (AxiDataWidth/8)<<MemAddrWidth is out of range:
//   write beat consumed with mem_req_o=0; B=SLVERR if any beat was out of range. Read beat issues no mem_req_o,
//   goes straight to READ_DATA with r.data=0, r.resp=SLVERR for that beat.
//  Undefined: no check; address bits above the SRAM range are ignored (aliasing), all responses OKAY.
// TESTING
//  1. Single write: AW addr=0x10,len=0,size=3,id=5; W data=0xDEAD_BEEF,strb=0xFF -> mem write addr 2, B id=5 OKAY.
//  2. INCR read len=3 from 0x0 after preloading 0..3 -> 4 R beats data 0..3, r.last only on 4th; r_ready gapped randomly, data stable.
//  3. Simultaneous aw_valid/ar_valid after reset -> write granted first, read next; repeat -> alternates.
//  4. FIXED write len=7 at 0x40 -> 8 mem writes all addr 8; b_ready low 5 cycles -> b_valid held, B fields stable.
//  5. rst_ni low 1 cycle mid 4-beat read after beat 2 -> all outputs 0 next cycle; new AR then served correctly.
//  6. AXI_MEM_RANGE_CHECK_EN, MemAddrWidth=4: write to 0x80 -> no mem_req_o, B=SLVERR; read -> r.data=0, SLVERR.

Source files
------------

// File: rtl/ariane_axi.sv
// Minimal ariane_axi request/response structs (ID 4, address 64, data 64, user 1) so the
// responder builds on its own.
package ariane_axi;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned UserWidth = 1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
    logic [UserWidth-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_mem_responder.sv
// AXI4 responder bridging one transaction at a time onto a single-port SRAM (1-cycle read latency).
// Define AXI_MEM_RANGE_CHECK_EN to answer SLVERR for beats beyond the SRAM instead of aliasing.
module axi_mem_responder #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned MemAddrWidth = 16,
  parameter type         req_t        = ariane_axi::req_t,
  parameter type         resp_t       = ariane_axi::resp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  req_t                      axi_req_i,
  output resp_t                     axi_resp_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MemAddrWidth-1:0]   mem_addr_o,
  output logic [AxiDataWidth-1:0]   mem_wdata_o,
  output logic [AxiDataWidth/8-1:0] mem_be_o,
  input  logic [AxiDataWidth-1:0]   mem_rdata_i
);

  localparam int unsigned OffWidth   = $clog2(AxiDataWidth / 8);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;
  localparam logic [1:0]  BurstFixed = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWriteResp,
    StReadReq,
    StReadData
  } state_e;

  state_e                  state_q, state_d;
  logic [AxiIdWidth-1:0]   id_q, id_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic                    last_grant_q, last_grant_d;  // 1: write won the most recent grant
  logic                    wr_err_q, wr_err_d;
  logic                    rd_err_q, rd_err_d;
  logic                    rdata_fresh_q, rdata_fresh_d;
  logic [AxiDataWidth-1:0] rdata_q, rdata_d;

  logic                    aw_grant, ar_grant;
  logic                    in_range;
  logic                    last_beat;
  logic [AxiAddrWidth-1:0] addr_next;
  logic                    unused_req;

  // Only the control/address subset of the request is consumed; atop, cache, prot etc. are ignored.
  assign unused_req = ^axi_req_i;

`ifdef AXI_MEM_RANGE_CHECK_EN
  assign in_range = (addr_q >> (OffWidth + MemAddrWidth)) == '0;
`else
  assign in_range = 1'b1;
`endif

  // Grants are held off during reset so nothing is accepted that the reset would then drop.
  assign aw_grant = rst_ni && (state_q == StIdle) && axi_req_i.aw_valid &&
                    (!axi_req_i.ar_valid || !last_grant_q);
  assign ar_grant = rst_ni && (state_q == StIdle) && axi_req_i.ar_valid &&
                    (!axi_req_i.aw_valid || last_grant_q);

  assign last_beat  = (cnt_q == len_q);
  assign mem_addr_o = addr_q[MemAddrWidth+OffWidth-1:OffWidth];

  // WRAP bursts deliberately take the INCR path.
  always_comb begin
    addr_next = addr_q;
    if (burst_q != BurstFixed) begin
      addr_next = addr_q + (AxiAddrWidth'(1) << size_q);
    end
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    size_d        = size_q;
    burst_d       = burst_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    wr_err_d      = wr_err_q;
    rd_err_d      = rd_err_q;
    rdata_fresh_d = 1'b0;
    rdata_d       = rdata_q;
    axi_resp_o    = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_wdata_o   = '0;
    mem_be_o      = '0;

    case (state_q)
      StIdle: begin
        axi_resp_o.aw_ready = aw_grant;
        axi_resp_o.ar_ready = ar_grant;
        if (aw_grant) begin
          id_d         = axi_req_i.aw.id;
          addr_d       = axi_req_i.aw.addr;
          len_d        = axi_req_i.aw.len;
          size_d       = axi_req_i.aw.size;
          burst_d      = axi_req_i.aw.burst;
          cnt_d        = '0;
          wr_err_d     = 1'b0;
          last_grant_d = 1'b1;
          state_d      = StWrite;
        end else if (ar_grant) begin
          id_d         = axi_req_i.ar.id;
          addr_d       = axi_req_i.ar.addr;
          len_d        = axi_req_i.ar.len;
          size_d       = axi_req_i.ar.size;
          burst_d      = axi_req_i.ar.burst;
          cnt_d        = '0;
          last_grant_d = 1'b0;
          state_d      = StReadReq;
        end
      end

      StWrite: begin
        axi_resp_o.w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          mem_req_o   = in_range;
          mem_we_o    = 1'b1;
          mem_wdata_o = axi_req_i.w.data;
          mem_be_o    = axi_req_i.w.strb;
          wr_err_d    = wr_err_q | ~in_range;
          addr_d      = addr_next;
          cnt_d       = cnt_q + 8'd1;
          // The beat count alone ends the burst; w.last is not trusted.
          if (last_beat) begin
            state_d = StWriteResp;
          end
        end
      end

      StWriteResp: begin
        axi_resp_o.b_valid = 1'b1;
        axi_resp_o.b.id    = id_q;
        axi_resp_o.b.resp  = wr_err_q ? RespSlvErr : RespOkay;
        if (axi_req_i.b_ready) begin
          state_d = StIdle;
        end
      end

      StReadReq: begin
        mem_req_o     = in_range;
        rd_err_d      = ~in_range;
        rdata_fresh_d = 1'b1;
        state_d       = StReadData;
      end

      StReadData: begin
        // First cycle forwards the SRAM output and captures it; later stall cycles replay the copy.
        if (rdata_fresh_q) begin
          rdata_d = mem_rdata_i;
        end
        axi_resp_o.r_valid = 1'b1;
        axi_resp_o.r.id    = id_q;
        axi_resp_o.r.data  = rd_err_q ? '0 : (rdata_fresh_q ? mem_rdata_i : rdata_q);
        axi_resp_o.r.resp  = rd_err_q ? RespSlvErr : RespOkay;
        axi_resp_o.r.last  = last_beat;
        if (axi_req_i.r_ready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            addr_d  = addr_next;
            cnt_d   = cnt_q + 8'd1;
            state_d = StReadReq;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      cnt_q         <= '0;
      last_grant_q  <= 1'b0;
      wr_err_q      <= 1'b0;
      rd_err_q      <= 1'b0;
      rdata_fresh_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      size_q        <= size_d;
      burst_q       <= burst_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      wr_err_q      <= wr_err_d;
      rd_err_q      <= rd_err_d;
      rdata_fresh_q <= rdata_fresh_d;
      rdata_q       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a behavioural SRAM and a log of SRAM writes.
module tb_axi_mem_responder;

`ifdef AXI_MEM_RANGE_CHECK_EN
  localparam int unsigned Maw = 4;
`else
  localparam int unsigned Maw = 16;
`endif
  localparam int Budget = 50;
  localparam logic [1:0] Incr  = 2'b01;
  localparam logic [1:0] Fixed = 2'b00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  ariane_axi::req_t  req;
  ariane_axi::resp_t resp;
  logic              mem_req, mem_we;
  logic [Maw-1:0]    mem_addr;
  logic [63:0]       mem_wdata, mem_rdata;
  logic [7:0]        mem_be;

  int n_cmp = 0;
  int n_err = 0;
  int req_cnt = 0;

  logic [63:0]    sram [2**Maw];
  logic [Maw-1:0] wlog_addr [$];
  logic [63:0]    wlog_data [$];
  logic [7:0]     wlog_be   [$];

  axi_mem_responder #(
    .MemAddrWidth (Maw)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .axi_req_i   (req),
    .axi_resp_o  (resp),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_wdata);
      wlog_be.push_back(mem_be);
    end
    if (mem_req && !mem_we) mem_rdata <= sram[mem_addr];
    if (mem_req) req_cnt++;
  end

  // ---------------- drive helpers (all start at a falling edge) ----------------
  task automatic drive_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
    req.aw = '0; req.aw.id = id; req.aw.addr = addr; req.aw.len = len;
    req.aw.size = 3'd3; req.aw.burst = burst; req.aw_valid = 1'b1;
  endtask

  task automatic drive_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
    req.ar = '0; req.ar.id = id; req.ar.addr = addr; req.ar.len = len;
    req.ar.size = 3'd3; req.ar.burst = burst; req.ar_valid = 1'b1;
  endtask

  task automatic hs_aw();
    bit hs = 1'b0;
    for (int i = 0; i < Budget && !hs; i++) begin
      #1 hs = resp.aw_ready;
      @(negedge clk);
    end
    req.aw_valid = 1'b0;
    if (!hs) begin n_cmp++; n_err++; $display("FAIL aw_handshake: aw_ready stayed 0, required 1"); end
  endtask

  task automatic hs_ar();
    bit hs = 1'b0;
    for (int i = 0; i < Budget && !hs; i++) begin
      #1 hs = resp.ar_ready;
      @(negedge clk);
    end
    req.ar_valid = 1'b0;
    if (!hs) begin n_cmp++; n_err++; $display("FAIL ar_handshake: ar_ready stayed 0, required 1"); end
  endtask

  task automatic hs_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    bit hs = 1'b0;
    req.w = '0; req.w.data = data; req.w.strb = strb; req.w.last = last; req.w_valid = 1'b1;
    for (int i = 0; i < Budget && !hs; i++) begin
      #1 hs = resp.w_ready;
      @(negedge clk);
    end
    req.w_valid = 1'b0;
    if (!hs) begin n_cmp++; n_err++; $display("FAIL w_handshake: w_ready stayed 0, required 1"); end
  endtask

  // Returns one time unit after a falling edge with b_valid seen (or after the budget expires).
  task automatic wait_b();
    bit seen = 1'b0;
    for (int i = 0; i < Budget && !seen; i++) begin
      #1 seen = resp.b_valid;
      if (!seen) @(negedge clk);
    end
    if (!seen) begin n_cmp++; n_err++; $display("FAIL b_wait: b_valid stayed 0, required 1"); end
  endtask

  task automatic wait_r();
    bit seen = 1'b0;
    for (int i = 0; i < Budget && !seen; i++) begin
      #1 seen = resp.r_valid;
      if (!seen) @(negedge clk);
    end
    if (!seen) begin n_cmp++; n_err++; $display("FAIL r_wait: r_valid stayed 0, required 1"); end
  endtask

  task automatic ack_b();
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
  endtask

  task automatic ack_r();
    req.r_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req.aw_valid = 1'b1;
    #1;
    n_cmp++; if (resp.aw_ready !== 1'b0) begin n_err++; $display("FAIL reset_aw_ready: got %b want 0", resp.aw_ready); end
    req.aw_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (resp !== '0) begin n_err++; $display("FAIL reset_resp: got %h want 0", resp); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int w0;
    w0 = wlog_addr.size();
    drive_aw(4'd5, 64'h10, 8'd0, Incr); hs_aw();
    hs_w(64'hDEAD_BEEF, 8'hFF, 1'b1);
    wait_b();
    n_cmp++; if (resp.b.id !== 4'd5) begin n_err++; $display("FAIL single_b_id: got %h want 5", resp.b.id); end
    n_cmp++; if (resp.b.resp !== 2'b00) begin n_err++; $display("FAIL single_b_resp: got %b want 00", resp.b.resp); end
    ack_b();
    n_cmp++; if (wlog_addr.size() !== w0 + 1) begin n_err++; $display("FAIL single_nwrites: got %0d want %0d", wlog_addr.size(), w0 + 1); end
    n_cmp++; if (wlog_addr[w0] !== Maw'(2)) begin n_err++; $display("FAIL single_addr: got %h want 2", wlog_addr[w0]); end
    n_cmp++; if (wlog_data[w0] !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", wlog_data[w0]); end
    n_cmp++; if (wlog_be[w0] !== 8'hFF) begin n_err++; $display("FAIL single_be: got %h want ff", wlog_be[w0]); end
  endtask

  task automatic test_incr_read();
    int w0;
    int gap;
    w0 = wlog_addr.size();
    drive_aw(4'd1, 64'h0, 8'd3, Incr); hs_aw();
    for (int i = 0; i < 4; i++) hs_w(64'(i), 8'hFF, i == 3);
    wait_b(); ack_b();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (wlog_addr[w0+i] !== Maw'(i)) begin n_err++; $display("FAIL preload_addr%0d: got %h want %h", i, wlog_addr[w0+i], i); end
    end
    drive_ar(4'd2, 64'h0, 8'd3, Incr); hs_ar();
    for (int i = 0; i < 4; i++) begin
      wait_r();
      n_cmp++; if (resp.r.data !== 64'(i)) begin n_err++; $display("FAIL incr_data%0d: got %h want %h", i, resp.r.data, i); end
      n_cmp++; if (resp.r.last !== (i == 3)) begin n_err++; $display("FAIL incr_last%0d: got %b want %b", i, resp.r.last, i == 3); end
      n_cmp++; if (resp.r.id !== 4'd2 || resp.r.resp !== 2'b00) begin n_err++; $display("FAIL incr_id_resp%0d: got %h/%b want 2/00", i, resp.r.id, resp.r.resp); end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); #1;
        n_cmp++; if (resp.r_valid !== 1'b1 || resp.r.data !== 64'(i)) begin n_err++; $display("FAIL incr_stall%0d: got v=%b d=%h want v=1 d=%h", i, resp.r_valid, resp.r.data, i); end
      end
      ack_r();
    end
    #1;
    n_cmp++; if (resp.r_valid !== 1'b0) begin n_err++; $display("FAIL incr_end: r_valid got %b want 0", resp.r_valid); end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    drive_aw(4'd1, 64'h20, 8'd0, Incr); drive_ar(4'd3, 64'h0, 8'd0, Incr);
    #1;
    n_cmp++; if ({resp.aw_ready, resp.ar_ready} !== 2'b10) begin n_err++; $display("FAIL arb_first: aw/ar_ready got %b%b want 10", resp.aw_ready, resp.ar_ready); end
    @(negedge clk); req.aw_valid = 1'b0;
    hs_w(64'h1111, 8'hFF, 1'b1);
    wait_b();
    n_cmp++; if (resp.b.id !== 4'd1) begin n_err++; $display("FAIL arb_b1_id: got %h want 1", resp.b.id); end
    ack_b();
    drive_aw(4'd4, 64'h28, 8'd0, Incr);
    #1;
    n_cmp++; if ({resp.aw_ready, resp.ar_ready} !== 2'b01) begin n_err++; $display("FAIL arb_second: aw/ar_ready got %b%b want 01", resp.aw_ready, resp.ar_ready); end
    @(negedge clk); req.ar_valid = 1'b0;
    wait_r();
    n_cmp++; if (resp.r.id !== 4'd3 || resp.r.data !== 64'h0) begin n_err++; $display("FAIL arb_r1: got id=%h d=%h want id=3 d=0", resp.r.id, resp.r.data); end
    ack_r();
    drive_ar(4'd6, 64'h20, 8'd0, Incr);
    #1;
    n_cmp++; if ({resp.aw_ready, resp.ar_ready} !== 2'b10) begin n_err++; $display("FAIL arb_third: aw/ar_ready got %b%b want 10", resp.aw_ready, resp.ar_ready); end
    @(negedge clk); req.aw_valid = 1'b0;
    hs_w(64'h2222, 8'hFF, 1'b1);
    wait_b();
    n_cmp++; if (resp.b.id !== 4'd4) begin n_err++; $display("FAIL arb_b2_id: got %h want 4", resp.b.id); end
    ack_b();
    hs_ar();
    wait_r();
    n_cmp++; if (resp.r.id !== 4'd6 || resp.r.data !== 64'h1111) begin n_err++; $display("FAIL arb_r2: got id=%h d=%h want id=6 d=1111", resp.r.id, resp.r.data); end
    ack_r();
  endtask

  task automatic test_fixed_write();
    int w0;
    w0 = wlog_addr.size();
    drive_aw(4'd9, 64'h40, 8'd7, Fixed); hs_aw();
    for (int i = 0; i < 8; i++) hs_w(64'hA0 + 64'(i), 8'hFF, i == 7);
    wait_b();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (resp.b_valid !== 1'b1 || resp.b.id !== 4'd9 || resp.b.resp !== 2'b00) begin n_err++; $display("FAIL fixed_b_hold%0d: got v=%b id=%h r=%b want v=1 id=9 r=00", k, resp.b_valid, resp.b.id, resp.b.resp); end
      @(negedge clk); #1;
    end
    ack_b(); #1;
    n_cmp++; if (resp.b_valid !== 1'b0) begin n_err++; $display("FAIL fixed_b_drop: got %b want 0", resp.b_valid); end
    @(negedge clk);
    n_cmp++; if (wlog_addr.size() !== w0 + 8) begin n_err++; $display("FAIL fixed_nwrites: got %0d want %0d", wlog_addr.size(), w0 + 8); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (wlog_addr[w0+i] !== Maw'(8) || wlog_data[w0+i] !== 64'hA0 + 64'(i)) begin n_err++; $display("FAIL fixed_beat%0d: got a=%h d=%h want a=8 d=%h", i, wlog_addr[w0+i], wlog_data[w0+i], 64'hA0 + 64'(i)); end
    end
  endtask

  task automatic test_reset_mid_read();
    drive_ar(4'd8, 64'h0, 8'd3, Incr); hs_ar();
    for (int i = 0; i < 2; i++) begin
      wait_r();
      n_cmp++; if (resp.r.data !== 64'(i)) begin n_err++; $display("FAIL midrst_data%0d: got %h want %h", i, resp.r.data, i); end
      ack_r();
    end
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (resp !== '0) begin n_err++; $display("FAIL midrst_resp: got %h want 0", resp); end
    n_cmp++; if ({mem_req, mem_we} !== 2'b00 || mem_addr !== '0) begin n_err++; $display("FAIL midrst_mem: got req=%b we=%b a=%h want 0", mem_req, mem_we, mem_addr); end
    @(negedge clk);
    drive_ar(4'd7, 64'h18, 8'd0, Incr); hs_ar();
    wait_r();
    n_cmp++; if (resp.r.data !== 64'h3 || resp.r.id !== 4'd7 || resp.r.last !== 1'b1 || resp.r.resp !== 2'b00) begin n_err++; $display("FAIL midrst_new: got d=%h id=%h l=%b r=%b want d=3 id=7 l=1 r=00", resp.r.data, resp.r.id, resp.r.last, resp.r.resp); end
    ack_r(); #1;
    n_cmp++; if (resp.r_valid !== 1'b0) begin n_err++; $display("FAIL midrst_end: r_valid got %b want 0", resp.r_valid); end
    @(negedge clk);
  endtask

`ifndef AXI_MEM_RANGE_CHECK_EN
  task automatic test_alias();
    int w0;
    w0 = wlog_addr.size();
    drive_aw(4'hA, 64'h8_0018, 8'd0, Incr); hs_aw();
    hs_w(64'h5555, 8'hFF, 1'b1);
    wait_b();
    n_cmp++; if (resp.b.resp !== 2'b00) begin n_err++; $display("FAIL alias_b_resp: got %b want 00", resp.b.resp); end
    ack_b();
    n_cmp++; if (wlog_addr[w0] !== Maw'(3)) begin n_err++; $display("FAIL alias_addr: got %h want 3", wlog_addr[w0]); end
    drive_ar(4'hB, 64'hFFFF_0000_0000_0018, 8'd0, Incr); hs_ar();
    wait_r();
    n_cmp++; if (resp.r.data !== 64'h5555 || resp.r.resp !== 2'b00) begin n_err++; $display("FAIL alias_read: got d=%h r=%b want d=5555 r=00", resp.r.data, resp.r.resp); end
    ack_r();
  endtask
`else
  task automatic test_range();
    int r0;
    int w0;
    r0 = req_cnt;
    drive_aw(4'd1, 64'h80, 8'd0, Incr); hs_aw();
    hs_w(64'h77, 8'hFF, 1'b1);
    wait_b();
    n_cmp++; if (resp.b.resp !== 2'b10) begin n_err++; $display("FAIL range_wr_resp: got %b want 10", resp.b.resp); end
    ack_b();
    n_cmp++; if (req_cnt !== r0) begin n_err++; $display("FAIL range_wr_strobe: got %0d strobes want 0", req_cnt - r0); end
    w0 = wlog_addr.size();
    drive_aw(4'd2, 64'h78, 8'd1, Incr); hs_aw();
    hs_w(64'h99, 8'hFF, 1'b0);
    hs_w(64'hAA, 8'hFF, 1'b1);
    wait_b();
    n_cmp++; if (resp.b.resp !== 2'b10) begin n_err++; $display("FAIL range_split_resp: got %b want 10", resp.b.resp); end
    ack_b();
    n_cmp++; if (wlog_addr.size() !== w0 + 1 || wlog_addr[w0] !== Maw'(15)) begin n_err++; $display("FAIL range_split_wr: got n=%0d a=%h want n=%0d a=f", wlog_addr.size(), wlog_addr[w0], w0 + 1); end
    r0 = req_cnt;
    drive_ar(4'd3, 64'h80, 8'd0, Incr); hs_ar();
    wait_r();
    n_cmp++; if (resp.r.data !== 64'h0 || resp.r.resp !== 2'b10 || resp.r.last !== 1'b1) begin n_err++; $display("FAIL range_rd: got d=%h r=%b l=%b want d=0 r=10 l=1", resp.r.data, resp.r.resp, resp.r.last); end
    ack_r();
    n_cmp++; if (req_cnt !== r0) begin n_err++; $display("FAIL range_rd_strobe: got %0d strobes want 0", req_cnt - r0); end
    drive_ar(4'd4, 64'h78, 8'd1, Incr); hs_ar();
    wait_r();
    n_cmp++; if (resp.r.data !== 64'h99 || resp.r.resp !== 2'b00) begin n_err++; $display("FAIL range_rd_beat0: got d=%h r=%b want d=99 r=00", resp.r.data, resp.r.resp); end
    ack_r();
    wait_r();
    n_cmp++; if (resp.r.data !== 64'h0 || resp.r.resp !== 2'b10) begin n_err++; $display("FAIL range_rd_beat1: got d=%h r=%b want d=0 r=10", resp.r.data, resp.r.resp); end
    ack_r();
  endtask
`endif

  initial begin
    req   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_write();
    test_incr_read();
    test_arbitration();
    test_fixed_write();
    test_reset_mid_read();
`ifndef AXI_MEM_RANGE_CHECK_EN
    test_alias();
`else
    test_range();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
